// File: rtl/march_bist_controller.sv
// March C- BIST engine: takes over the RAM through the BIST side of the muxes,
// walks M0..M5 and reports done/fail with the first failing address.
module march_bist_controller #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              test_mode_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic              bist_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  localparam int unsigned ELEM_W = 3;
  localparam logic [ELEM_W-1:0] ELEM_FIRST_DOWN = ELEM_W'(3);
  localparam logic [ELEM_W-1:0] ELEM_LAST       = ELEM_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_MAX        = '1;
  localparam logic [DATA_W-1:0] PAT0            = '0;
  localparam logic [DATA_W-1:0] PAT1            = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CMP,
    DONE
  } state_e;

  state_e              state_q;
  logic [ELEM_W-1:0]   elem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   bist_din_q;
  logic                bist_we_q;
  logic                test_mode_q;
  logic                busy_q;
  logic                done_q;
  logic                fail_q;
  logic [ADDR_W-1:0]   fail_addr_q;

  logic                last_addr;
  logic                run_end;
  logic                mismatch;
  logic [ELEM_W-1:0]   adv_elem;
  logic [ADDR_W-1:0]   adv_addr;

  function automatic logic is_down(input logic [ELEM_W-1:0] e);
    return e >= ELEM_FIRST_DOWN;
  endfunction

  // M1 and M3 write ones; M0, M2 and M4 write zeros.
  function automatic logic [DATA_W-1:0] wr_pat(input logic [ELEM_W-1:0] e);
    return (e == ELEM_W'(1) || e == ELEM_W'(3)) ? PAT1 : PAT0;
  endfunction

  // M2 and M4 expect ones; M1, M3 and M5 expect zeros.
  function automatic logic [DATA_W-1:0] exp_pat(input logic [ELEM_W-1:0] e);
    return (e == ELEM_W'(2) || e == ELEM_W'(4)) ? PAT1 : PAT0;
  endfunction

  // Position of the next address once all ops of the current one are done.
  always_comb begin
    last_addr = is_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
    run_end   = last_addr && (elem_q == ELEM_LAST);
    mismatch  = (ram_dout_i != exp_pat(elem_q));
    adv_elem  = elem_q;
    adv_addr  = addr_q;
    if (last_addr) begin
      adv_elem = elem_q + ELEM_W'(1);
      adv_addr = is_down(adv_elem) ? ADDR_MAX : '0;
    end else if (is_down(elem_q)) begin
      adv_addr = addr_q - ADDR_W'(1);
    end else begin
      adv_addr = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      bist_din_q  <= '0;
      bist_we_q   <= 1'b0;
      test_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= WR;
            elem_q      <= '0;
            addr_q      <= '0;
            bist_din_q  <= PAT0;
            bist_we_q   <= 1'b1;
            test_mode_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
          end
        end

        WR: begin
          state_q    <= (adv_elem == '0) ? WR : RD;
          elem_q     <= adv_elem;
          addr_q     <= adv_addr;
          bist_we_q  <= (adv_elem == '0);
          bist_din_q <= '0;
        end

        RD: begin
          state_q <= CMP;
        end

        CMP: begin
          if (mismatch || run_end) begin
            // Abort or normal completion: release the RAM immediately.
            state_q     <= DONE;
            elem_q      <= '0;
            addr_q      <= '0;
            bist_we_q   <= 1'b0;
            bist_din_q  <= '0;
            test_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            if (mismatch) begin
              fail_q      <= 1'b1;
              fail_addr_q <= addr_q;
            end
          end else if (elem_q == ELEM_LAST) begin
            state_q    <= RD;
            elem_q     <= adv_elem;
            addr_q     <= adv_addr;
            bist_we_q  <= 1'b0;
            bist_din_q <= '0;
          end else begin
            state_q    <= WR;
            bist_we_q  <= 1'b1;
            bist_din_q <= wr_pat(elem_q);
          end
        end

        default: begin
          state_q     <= IDLE;
          bist_we_q   <= 1'b0;
          bist_din_q  <= '0;
          test_mode_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign test_mode_o = test_mode_q;
  assign bist_addr_o = addr_q;
  assign bist_din_o  = bist_din_q;
  assign bist_we_o   = bist_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: tb/tb_march_bist_controller.sv
// Scoreboard bench for march_bist_controller: a March C- op-list model with an
// injectable faulty RAM predicts every BIST cycle and the final verdict.
module tb_march_bist_controller;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] ram_dout;
  logic          test_mode;
  logic [AW-1:0] bist_addr;
  logic [DW-1:0] bist_din;
  logic          bist_we;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;

  always #5 clk = ~clk;

  march_bist_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .ram_dout_i  (ram_dout),
    .test_mode_o (test_mode),
    .bist_addr_o (bist_addr),
    .bist_din_o  (bist_din),
    .bist_we_o   (bist_we),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_addr_o (fail_addr)
  );

  // Fault selection: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 idempotent coupling.
  int ftype = 0;
  int faddr = 0;
  int fbit  = 0;
  int fagg  = 0;
  int fvic  = 1;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] m;
    m = DW'(1) << fbit;
    if (ftype == 1 && a == faddr) return v & ~m;
    if (ftype == 2 && a == faddr) return v | m;
    return v;
  endfunction

  // RAM behind the mux; functional side is parked at address 0 with no writes.
  logic [DW-1:0] mem [N];
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  assign ram_addr = test_mode ? bist_addr : '0;
  assign ram_we   = test_mode & bist_we;

  always @(posedge clk) begin
    ram_dout <= rd_fault(mem[ram_addr], int'(ram_addr));
    if (ram_we) begin
      mem[ram_addr] <= bist_din;
      if (ftype == 3 && int'(ram_addr) == fagg) mem[fvic] <= bist_din;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] din;
  } cyc_t;

  typedef struct {
    logic          fail;
    logic [AW-1:0] faddr;
    int            cycles;
    int            writes;
  } res_t;

  cyc_t exp_q[$];
  res_t res_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int run_active = 0;
  int last_cycles = 0;
  int last_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: expand the March C- element table into per-cycle ops.
  task automatic build_expected();
    string       el [6];
    string       s;
    logic [DW-1:0] m [N];
    logic [DW-1:0] pat;
    res_t        r;
    cyc_t        c;
    int          a;
    bit          stop;
    el[0] = "w0"; el[1] = "r0w1"; el[2] = "r1w0";
    el[3] = "r0w1"; el[4] = "r1w0"; el[5] = "r0";
    r.fail = 1'b0; r.faddr = '0; r.cycles = 0; r.writes = 0;
    stop = 1'b0;
    for (int i = 0; i < int'(N); i++) m[i] = '0;
    for (int e = 0; e < 6 && !stop; e++) begin
      s = el[e];
      for (int k = 0; k < int'(N) && !stop; k++) begin
        a = (e >= 3) ? int'(N) - 1 - k : k;
        for (int i = 0; i < s.len() && !stop; i += 2) begin
          pat = (s[i+1] == "1") ? '1 : '0;
          c.addr = AW'(a);
          if (s[i] == "w") begin
            c.we = 1'b1; c.din = pat;
            exp_q.push_back(c);
            r.cycles++; r.writes++;
            m[a] = pat;
            if (ftype == 3 && a == fagg) m[fvic] = pat;
          end else begin
            c.we = 1'b0; c.din = '0;
            exp_q.push_back(c);
            exp_q.push_back(c);
            r.cycles += 2;
            if (rd_fault(m[a], a) !== pat) begin
              r.fail = 1'b1; r.faddr = AW'(a); stop = 1'b1;
            end
          end
        end
      end
    end
    res_q.push_back(r);
  endtask

  // Monitor: pops one expected op per BIST cycle and the verdict when done rises.
  cyc_t mon_c;
  res_t mon_r;
  logic prev_tm = 1'b0;
  bit   done_seen = 1'b0;
  int   run_cycles = 0;
  int   run_writes = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_tm   = 1'b0;
      done_seen = 1'b0;
    end else begin
      if (test_mode) begin
        if (!prev_tm) begin
          run_cycles = 0; run_writes = 0; done_seen = 1'b0;
        end
        run_cycles++;
        if (bist_we) run_writes++;
        chk("busy_during_run", {30'd0, busy, done}, 32'd2);
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL trace_overrun: got op cycle at addr %0h expected none (t=%0t)", bist_addr, $time);
        end else begin
          mon_c = exp_q.pop_front();
          chk("trace_addr", 32'(bist_addr), 32'(mon_c.addr));
          chk("trace_we",   32'(bist_we),   32'(mon_c.we));
          chk("trace_din",  32'(bist_din),  32'(mon_c.din));
        end
      end else begin
        chk("idle_we_din", {23'd0, bist_we, bist_din}, 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        if (prev_tm) chk("done_after_last_op", 32'(done), 32'd1);
        if (done && !done_seen) begin
          done_seen = 1'b1;
          if (res_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
          end else begin
            mon_r = res_q.pop_front();
            chk("trace_drained", 32'(exp_q.size()), 32'd0);
            chk("fail_flag", 32'(fail), 32'(mon_r.fail));
            chk("fail_addr", 32'(fail_addr), 32'(mon_r.faddr));
            chk("op_cycles", 32'(run_cycles), 32'(mon_r.cycles));
            chk("we_pulses", 32'(run_writes), 32'(mon_r.writes));
          end
          last_cycles = run_cycles;
          last_writes = run_writes;
          run_active  = 0;
        end
      end
      prev_tm = test_mode;
    end
  end

  task automatic do_start();
    bit fresh;
    @(posedge clk); #1;
    start = 1'b1;
    fresh = (run_active == 0);
    if (fresh) begin
      build_expected();
      run_active = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (fresh) begin
      chk("start_clears", {22'd0, done, fail, fail_addr}, 32'd0);
      chk("start_takeover", {29'd0, test_mode, busy, bist_we}, 32'd7);
      chk("start_addr", 32'(bist_addr), 32'd0);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (run_active != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (run_active != 0) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: got busy after %0d cycles expected done", t);
      exp_q.delete(); res_q.delete();
      run_active = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); res_q.delete();
    run_active = 0;
    #1;
    chk("reset_outputs", {9'd0, test_mode, busy, done, fail, bist_we, fail_addr, bist_addr, bist_din}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic rand_fault();
    ftype = $urandom_range(0, 3);
    faddr = $urandom_range(0, N - 1);
    fbit  = $urandom_range(0, DW - 1);
    fagg  = $urandom_range(0, N - 1);
    fvic  = (fagg + $urandom_range(1, N - 1)) % N;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < int'(N); i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {9'd0, test_mode, busy, done, fail, bist_we, fail_addr, bist_addr, bist_din}, 32'd0);
    rst = 1'b0;

    // Fault-free run: 60 op cycles, 20 writes, clean verdict.
    ftype = 0;
    do_start();
    wait_done();
    chk("clean_done", {29'd0, done, fail, busy}, 32'd4);
    chk("clean_fail_addr", 32'(fail_addr), 32'd0);
    chk("clean_cycles", 32'(last_cycles), 32'd60);
    chk("clean_writes", 32'(last_writes), 32'd20);

    // Bit 3 of address 2 stuck at 1: caught by the M1 read of address 2.
    ftype = 2; faddr = 2; fbit = 3;
    do_start();
    wait_done();
    chk("sa1_verdict", {29'd0, done, fail, test_mode}, 32'd6);
    chk("sa1_fail_addr", 32'(fail_addr), 32'd2);

    // Bit 0 of address 1 stuck at 0: caught by the M2 read of address 1.
    ftype = 1; faddr = 1; fbit = 0;
    do_start();
    wait_done();
    chk("sa0_verdict", {30'd0, done, fail}, 32'd3);
    chk("sa0_fail_addr", 32'(fail_addr), 32'd1);

    // Mid-run start pulses are ignored; a start after done clears fail and reruns.
    ftype = 0;
    do_start();
    repeat (3) @(posedge clk);
    do_start();
    repeat (22) @(posedge clk);
    do_start();
    wait_done();
    do_start();
    wait_done();
    chk("rerun_cycles", 32'(last_cycles), 32'd60);

    // Reset around cycle 20, then a full clean run.
    do_start();
    repeat (17) @(posedge clk);
    do_reset();
    do_start();
    wait_done();
    chk("post_reset_cycles", 32'(last_cycles), 32'd60);
    chk("post_reset_fail", 32'(fail), 32'd0);

    // Reset and start together: reset wins.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_beats_start", {29'd0, test_mode, busy, done}, 32'd0);
    rst = 1'b0; start = 1'b0;

    // Randomized faults, stray start pulses and mid-run resets.
    for (int it = 0; it < 24; it++) begin
      rand_fault();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      do_start();
      if (ftype == 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        do_start();
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        do_reset();
      end else begin
        wait_done();
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
